// File: rtl/yuv_pack_pkg.sv
// Shared definitions for the YUV plane packer.
// Holds the chroma subsampling mode encoding, default lane counts and widths
// used as parameter defaults by the top, and a helper that folds the reserved
// mode code onto 4:2:0.
package yuv_pack_pkg;

    typedef enum logic [1:0] {
        MODE_444 = 2'd0,
        MODE_422 = 2'd1,
        MODE_420 = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    localparam int DEF_PIX_W   = 8;
    localparam int DEF_Y_LANES = 5;
    localparam int DEF_C_LANES = 18;
    localparam int DEF_Y_AW    = 16;
    localparam int DEF_C_AW    = 13;
    localparam int DEF_Y_DEPTH = 61440;
    localparam int DEF_C_DEPTH = 8192;
    localparam int DEF_IMG_W   = 640;
    localparam int DEF_IMG_H   = 480;

    // The reserved code behaves exactly like 4:2:0.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_420 : mode_e'(m);
    endfunction

endpackage

// File: rtl/lane_packer.sv
// Packs a stream of PIX_W samples into LANES-wide words for one plane.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            discard the partial word and restart addressing at 0
//   push, sample   sample to append in the next free lane
//   flush          write out a non-empty partial word (unused lanes zero)
//   wdata/waddr    registered write data / address
//   wren           one-cycle write strobe, cycle after the completing push
//   ovf            combinational pulse: a word was due but the buffer is full
module lane_packer #(
    parameter int LANES = 18,
    parameter int PIX_W = 8,
    parameter int AW    = 13,
    parameter int DEPTH = 8192
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   flush,
    input  logic [PIX_W-1:0]       sample,
    output logic [LANES*PIX_W-1:0] wdata,
    output logic [AW-1:0]          waddr,
    output logic                   wren,
    output logic                   ovf
);

    localparam int WW = LANES * PIX_W;
    localparam int LW = $clog2(LANES + 1);
    // Write counter can reach DEPTH itself, which may not fit in AW bits.
    localparam int CW = $clog2(DEPTH + 1);

    logic [WW-1:0] acc_q, acc_d, acc_base, word;
    logic [LW-1:0] lane_q, lane_d, lane_base, fill;
    logic [CW-1:0] cnt_q, cnt_d, cnt_base;
    logic [WW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          wren_q, wren_d;
    logic          emit;

    always_comb begin
        // clr takes effect before this cycle's sample is placed, so the
        // sample that arrives with clr becomes lane 0 of a fresh word.
        acc_base  = clr ? '0 : acc_q;
        lane_base = clr ? '0 : lane_q;
        cnt_base  = clr ? '0 : cnt_q;

        word = acc_base;
        for (int i = 0; i < LANES; i++) begin
            if (push && (lane_base == LW'(i))) begin
                word[i*PIX_W +: PIX_W] = sample;
            end
        end
        fill = lane_base + LW'(push);
        emit = (fill == LW'(LANES)) || (flush && (fill != '0));

        acc_d   = word;
        lane_d  = fill;
        cnt_d   = cnt_base;
        wdata_d = wdata_q;
        waddr_d = clr ? '0 : waddr_q;
        wren_d  = 1'b0;
        ovf     = 1'b0;

        if (emit) begin
            acc_d   = '0;
            lane_d  = '0;
            // On a suppressed write the address output shows the held count.
            waddr_d = AW'(cnt_base);
            if (cnt_base < CW'(DEPTH)) begin
                wren_d  = 1'b1;
                wdata_d = word;
                cnt_d   = cnt_base + CW'(1);
            end else begin
                ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            wren_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            wren_q  <= wren_d;
        end
    end

    assign wdata = wdata_q;
    assign waddr = waddr_q;
    assign wren  = wren_q;

endmodule

// File: rtl/yuv_plane_packer.sv
// Packs a per-pixel Y/U/V stream into per-plane frame-buffer words.
// Ports:
//   MIPI_PIXEL_CLK, RESET_N   clock, asynchronous active-low reset
//   mode                      subsampling mode, latched on sof
//   pix_valid, sof, eol       pixel qualifier, first-of-frame, last-of-line
//   pix_y/u/v                 samples
//   y_*, u_*, v_*             per-plane write ports (data, address, strobe)
//   frame_done                pulse aligned with the last line's flush writes
//   err_ovf, err_geom         sticky errors, cleared at sof
module yuv_plane_packer
    import yuv_pack_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int Y_LANES = DEF_Y_LANES,
    parameter int C_LANES = DEF_C_LANES,
    parameter int Y_AW    = DEF_Y_AW,
    parameter int C_AW    = DEF_C_AW,
    parameter int Y_DEPTH = DEF_Y_DEPTH,
    parameter int C_DEPTH = DEF_C_DEPTH,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H
) (
    input  logic                     MIPI_PIXEL_CLK,
    input  logic                     RESET_N,
    input  logic [1:0]               mode,
    input  logic                     pix_valid,
    input  logic                     sof,
    input  logic                     eol,
    input  logic [PIX_W-1:0]         pix_y,
    input  logic [PIX_W-1:0]         pix_u,
    input  logic [PIX_W-1:0]         pix_v,
    output logic [Y_LANES*PIX_W-1:0] y_data,
    output logic [Y_AW-1:0]          y_addr,
    output logic                     y_wren,
    output logic [C_LANES*PIX_W-1:0] u_data,
    output logic [C_LANES*PIX_W-1:0] v_data,
    output logic [C_AW-1:0]          u_addr,
    output logic [C_AW-1:0]          v_addr,
    output logic                     u_wren,
    output logic                     v_wren,
    output logic                     frame_done,
    output logic                     err_ovf,
    output logic                     err_geom
);

    localparam int CLW = $clog2(IMG_W + 1);
    localparam int RLW = $clog2(IMG_H + 1);

    logic [CLW-1:0] col_q, col_d, col_base;
    logic [RLW-1:0] row_q, row_d, row_base;
    mode_e          mode_q, mode_d, mode_eff;
    logic           active_q, active_d;
    logic           frame_done_q, frame_done_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_geom_q, err_geom_d;
    logic           take, start, in_geom, keep, flush;
    logic           y_push, u_push, v_push;
    logic           y_ovf, u_ovf, v_ovf;

    always_comb begin
        start    = pix_valid && sof;
        // Until the first sof after reset every pixel is ignored silently.
        take     = pix_valid && (active_q || sof);
        col_base = start ? '0 : col_q;
        row_base = start ? '0 : row_q;
        mode_eff = start ? norm_mode(mode) : mode_q;
        in_geom  = (col_base < CLW'(IMG_W)) && (row_base < RLW'(IMG_H));
        keep     = take && in_geom;
        // A dropped eol pixel still closes the line for the in-range data.
        flush    = take && eol;

        y_push = keep;
        case (mode_eff)
            MODE_444: begin
                u_push = keep;
                v_push = keep;
            end
            MODE_422: begin
                u_push = keep && !col_base[0];
                v_push = keep && !col_base[0];
            end
            default: begin
                u_push = keep && !col_base[0] && !row_base[0];
                v_push = keep && !col_base[0] &&  row_base[0];
            end
        endcase

        active_d = active_q || start;
        mode_d   = mode_eff;
        col_d    = col_q;
        row_d    = row_q;
        if (take) begin
            // Both counters saturate one past the image so runaway input
            // keeps flagging geometry errors instead of wrapping.
            if (eol) begin
                col_d = '0;
                row_d = (row_base == RLW'(IMG_H)) ? row_base : row_base + RLW'(1);
            end else begin
                col_d = (col_base == CLW'(IMG_W)) ? col_base : col_base + CLW'(1);
                row_d = row_base;
            end
        end

        frame_done_d = take && eol && (row_base == RLW'(IMG_H - 1));
        err_geom_d   = (start ? 1'b0 : err_geom_q) | (take && !in_geom);
        err_ovf_d    = (start ? 1'b0 : err_ovf_q) | y_ovf | u_ovf | v_ovf;
    end

    always_ff @(posedge MIPI_PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= MODE_420;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_geom_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
            err_ovf_q    <= err_ovf_d;
            err_geom_q   <= err_geom_d;
        end
    end

    lane_packer #(.LANES(Y_LANES), .PIX_W(PIX_W), .AW(Y_AW), .DEPTH(Y_DEPTH)) u_y_pack (
        .clk(MIPI_PIXEL_CLK), .rst_n(RESET_N), .clr(start), .push(y_push),
        .flush(flush), .sample(pix_y), .wdata(y_data), .waddr(y_addr),
        .wren(y_wren), .ovf(y_ovf)
    );

    lane_packer #(.LANES(C_LANES), .PIX_W(PIX_W), .AW(C_AW), .DEPTH(C_DEPTH)) u_u_pack (
        .clk(MIPI_PIXEL_CLK), .rst_n(RESET_N), .clr(start), .push(u_push),
        .flush(flush), .sample(pix_u), .wdata(u_data), .waddr(u_addr),
        .wren(u_wren), .ovf(u_ovf)
    );

    lane_packer #(.LANES(C_LANES), .PIX_W(PIX_W), .AW(C_AW), .DEPTH(C_DEPTH)) u_v_pack (
        .clk(MIPI_PIXEL_CLK), .rst_n(RESET_N), .clr(start), .push(v_push),
        .flush(flush), .sample(pix_v), .wdata(v_data), .waddr(v_addr),
        .wren(v_wren), .ovf(v_ovf)
    );

    assign frame_done = frame_done_q;
    assign err_ovf    = err_ovf_q;
    assign err_geom   = err_geom_q;

endmodule

// File: tb/tb_yuv_plane_packer.sv
module tb_yuv_plane_packer;

    localparam int PIX_W = 8, Y_LANES = 5, C_LANES = 18;
    localparam int Y_AW = 8, C_AW = 4, Y_DEPTH = 64, C_DEPTH = 2;
    localparam int IMG_W = 10, IMG_H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        pix_valid = 1'b0, sof = 1'b0, eol = 1'b0;
    logic [7:0]  pix_y = '0, pix_u = '0, pix_v = '0;
    logic [39:0] y_data;
    logic [7:0]  y_addr;
    logic        y_wren;
    logic [143:0] u_data, v_data;
    logic [3:0]  u_addr, v_addr;
    logic        u_wren, v_wren, frame_done, err_ovf, err_geom;

    yuv_plane_packer #(
        .PIX_W(PIX_W), .Y_LANES(Y_LANES), .C_LANES(C_LANES), .Y_AW(Y_AW), .C_AW(C_AW),
        .Y_DEPTH(Y_DEPTH), .C_DEPTH(C_DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .MIPI_PIXEL_CLK(clk), .RESET_N(rst_n), .mode(mode), .pix_valid(pix_valid),
        .sof(sof), .eol(eol), .pix_y(pix_y), .pix_u(pix_u), .pix_v(pix_v),
        .y_data(y_data), .y_addr(y_addr), .y_wren(y_wren),
        .u_data(u_data), .v_data(v_data), .u_addr(u_addr), .v_addr(v_addr),
        .u_wren(u_wren), .v_wren(v_wren), .frame_done(frame_done),
        .err_ovf(err_ovf), .err_geom(err_geom)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0, fd_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Per plane: list of samples waiting for the current word, and the number
    // of words written this frame.
    logic [7:0] mbuf [3][18];
    int         mfill [3];
    int         mwords [3];
    int         m_col, m_row, m_mode;
    bit         m_active, m_eovf, m_egeom;
    // expected outputs for the cycle after the pixel now on the inputs
    bit           pe_wren [3];
    logic [143:0] pe_data [3];
    int           pe_addr [3];
    bit           pe_fd, pe_eovf, pe_egeom;
    // expected outputs for the current cycle
    bit           ce_wren [3];
    logic [143:0] ce_data [3];
    int           ce_addr [3];
    bit           ce_fd, ce_eovf, ce_egeom;

    function automatic int lanes_of(input int p);
        return (p == 0) ? Y_LANES : C_LANES;
    endfunction

    function automatic int depth_of(input int p);
        return (p == 0) ? Y_DEPTH : C_DEPTH;
    endfunction

    task automatic model_idle();
        for (int p = 0; p < 3; p++) pe_wren[p] = 1'b0;
        pe_fd = 1'b0;
        pe_eovf = m_eovf;
        pe_egeom = m_egeom;
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_eovf = 1'b0; m_egeom = 1'b0;
        m_col = 0; m_row = 0; m_mode = 2;
        for (int p = 0; p < 3; p++) begin mfill[p] = 0; mwords[p] = 0; end
        model_idle();
    endtask

    task automatic model_push(input int p, input logic [7:0] s);
        mbuf[p][mfill[p]] = s;
        mfill[p]++;
    endtask

    task automatic model_pixel(input bit s, input bit e, input logic [7:0] y,
                               input logic [7:0] u, input logic [7:0] v, input logic [1:0] md);
        logic [143:0] word;
        model_idle();
        if (s) begin
            m_active = 1'b1; m_col = 0; m_row = 0;
            m_mode = (md == 2'd3) ? 2 : int'(md);
            m_eovf = 1'b0; m_egeom = 1'b0;
            for (int p = 0; p < 3; p++) begin mfill[p] = 0; mwords[p] = 0; end
        end
        if (m_active) begin
            if (m_col >= IMG_W || m_row >= IMG_H) begin
                m_egeom = 1'b1;
            end else begin
                model_push(0, y);
                if (m_mode == 0 || (m_mode == 1 && m_col % 2 == 0)) begin
                    model_push(1, u); model_push(2, v);
                end else if (m_mode == 2 && m_col % 2 == 0) begin
                    if (m_row % 2 == 0) model_push(1, u);
                    else model_push(2, v);
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (mfill[p] == lanes_of(p) || (e && mfill[p] > 0)) begin
                    word = '0;
                    for (int i = 0; i < mfill[p]; i++)
                        word = word | ({136'd0, mbuf[p][i]} << (8 * i));
                    if (mwords[p] < depth_of(p)) begin
                        pe_wren[p] = 1'b1; pe_data[p] = word; pe_addr[p] = mwords[p];
                        mwords[p]++;
                    end else begin
                        m_eovf = 1'b1;
                    end
                    mfill[p] = 0;
                end
            end
            pe_fd = e && (m_row == IMG_H - 1);
            if (e) begin m_col = 0; m_row++; end
            else m_col++;
        end
        pe_eovf = m_eovf;
        pe_egeom = m_egeom;
    endtask

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            ce_wren[p] = pe_wren[p]; ce_data[p] = pe_data[p]; ce_addr[p] = pe_addr[p];
        end
        ce_fd = pe_fd; ce_eovf = pe_eovf; ce_egeom = pe_egeom;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("y_wren", y_wren, ce_wren[0]);
            check("u_wren", u_wren, ce_wren[1]);
            check("v_wren", v_wren, ce_wren[2]);
            if (ce_wren[0]) begin check("y_data", y_data, ce_data[0]); check("y_addr", y_addr, ce_addr[0]); end
            if (ce_wren[1]) begin check("u_data", u_data, ce_data[1]); check("u_addr", u_addr, ce_addr[1]); end
            if (ce_wren[2]) begin check("v_data", v_data, ce_data[2]); check("v_addr", v_addr, ce_addr[2]); end
            check("frame_done", frame_done, ce_fd);
            check("err_ovf", err_ovf, ce_eovf);
            check("err_geom", err_geom, ce_egeom);
            if (frame_done) fd_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic px(input bit s, input bit e, input logic [7:0] y, input logic [7:0] u,
                      input logic [7:0] v, input logic [1:0] md);
        pix_valid = 1'b1; sof = s; eol = e; pix_y = y; pix_u = u; pix_v = v; mode = md;
        model_pixel(s, e, y, u, v, md);
        @(posedge clk); #1;
        pix_valid = 1'b0; sof = 1'b0; eol = 1'b0;
        model_idle();
    endtask

    task automatic line(input bit s, input int n, input logic [1:0] md, input logic [7:0] yb);
        for (int i = 0; i < n; i++)
            px(s && i == 0, i == n - 1, yb + 8'(i), 8'h10 + 8'(i), 8'h20 + 8'(i), md);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_y_wren"}, y_wren, 0); check({tag, "_u_wren"}, u_wren, 0);
        check({tag, "_v_wren"}, v_wren, 0); check({tag, "_y_addr"}, y_addr, 0);
        check({tag, "_y_data"}, y_data, 0); check({tag, "_u_data"}, u_data, 0);
        check({tag, "_frame_done"}, frame_done, 0); check({tag, "_err_ovf"}, err_ovf, 0);
        check({tag, "_err_geom"}, err_geom, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // pixels before the first sof are ignored without error
        line(0, 3, 2'd0, 8'h50);

        // 4:4:4 ramp, two Y words
        for (int i = 0; i < 10; i++) begin
            px(i == 0, i == 9, 8'(i), 8'h10 + 8'(i), 8'h20 + 8'(i), 2'd0);
            if (i == 4) begin
                check("t1_w0_wren", y_wren, 1); check("t1_w0_data", y_data, 40'h0403020100);
                check("t1_w0_addr", y_addr, 0);
            end
            if (i == 9) begin
                check("t1_w1_wren", y_wren, 1); check("t1_w1_data", y_data, 40'h0908070605);
                check("t1_w1_addr", y_addr, 1);
            end
        end
        repeat (2) begin @(posedge clk); #1; end

        // 4:2:2, six-pixel line
        line(1, 6, 2'd1, 8'h00);
        check("t2_u_wren", u_wren, 1); check("t2_u_data", u_data, 144'h141210);
        check("t2_v_data", v_data, 144'h242220); check("t2_u_addr", u_addr, 0);

        // 4:2:0, two lines
        line(1, 4, 2'd2, 8'h00);
        check("t3_r0_u", u_wren, 1); check("t3_r0_v", v_wren, 0);
        line(0, 4, 2'd2, 8'h00);
        check("t3_r1_u", u_wren, 0); check("t3_r1_v", v_wren, 1); check("t3_r1_vaddr", v_addr, 0);

        // chroma overflow at depth 2
        line(1, 2, 2'd0, 8'h00);
        line(0, 2, 2'd0, 8'h00);
        line(0, 2, 2'd0, 8'h00);
        check("t4_u_wren", u_wren, 0); check("t4_u_addr", u_addr, 2); check("t4_err_ovf", err_ovf, 1);

        // sof mid-line discards pending samples
        line(1, 3, 2'd0, 8'h00);   // line helper ends with eol; use single pixels instead below
        px(1, 0, 8'h30, 8'h00, 8'h00, 2'd0);
        px(0, 0, 8'h31, 8'h00, 8'h00, 2'd0);
        px(0, 0, 8'h32, 8'h00, 8'h00, 2'd0);
        px(1, 0, 8'hA0, 8'h00, 8'h00, 2'd0);
        check("t5_err_ovf_clr", err_ovf, 0);
        check("t5_no_y_write", y_wren, 0);
        for (int i = 1; i < 5; i++) px(0, 0, 8'hA0 + 8'(i), 8'h00, 8'h00, 2'd0);
        check("t5_y_wren", y_wren, 1); check("t5_y_addr", y_addr, 0);
        check("t5_lane0", {136'd0, y_data[7:0]}, 144'hA0);
        px(0, 1, 8'hA5, 8'h00, 8'h00, 2'd0);

        // geometry: full frame, then a row past the bottom
        fd_cnt = 0;
        line(1, 2, 2'd2, 8'h00);
        line(0, 2, 2'd2, 8'h02);
        line(0, 2, 2'd2, 8'h04);
        line(0, 2, 2'd2, 8'h06);
        check("t6_err_geom_before", err_geom, 0);
        px(0, 0, 8'h77, 8'h00, 8'h00, 2'd2);
        check("t6_err_geom", err_geom, 1);
        check("t6_fd_cnt", fd_cnt, 1);

        // column overflow
        line(1, 11, 2'd1, 8'h00);
        check("t7_err_geom", err_geom, 1);

        // reset mid-frame
        px(1, 0, 8'h01, 8'h02, 8'h03, 2'd0);
        px(0, 0, 8'h04, 8'h05, 8'h06, 2'd0);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        line(0, 6, 2'd0, 8'h40);
        repeat (3) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/yuv_plane_packer.md
Name: yuv_plane_packer

Overview:
Parametrised pixel-to-frame-buffer packer for the camera path. Takes a per-pixel Y/U/V stream from the colour converter and packs each plane into wide frame-buffer words, with a per-plane write port (data, address, write enable). Adds selectable chroma subsampling, end-of-line flush of partial words, per-plane overflow protection and frame-done signalling. Sits between the RGB-to-YUV stage and the on-chip frame-buffer RAMs.

Parameters:
PIX_W, 8, bits per sample
Y_LANES, 5, Y samples per Y word (Y word width = Y_LANES*PIX_W)
C_LANES, 18, chroma samples per U/V word
Y_AW, 16, Y address width
C_AW, 13, U/V address width
Y_DEPTH, 61440, Y words per frame buffer
C_DEPTH, 8192, U/V words per frame buffer
IMG_W, 640, pixels per line
IMG_H, 480, lines per frame

Ports:
MIPI_PIXEL_CLK  in  1  sole clock
RESET_N  in  1  asynchronous active-low reset
mode  in  2  0=4:4:4, 1=4:2:2, 2=4:2:0 (U even rows, V odd rows), 3=reserved (treated as 2); sampled only at sof
pix_valid  in  1  sample qualifier
sof  in  1  with pix_valid: this pixel is first of frame
eol  in  1  with pix_valid: this pixel is last of line
pix_y, pix_u, pix_v  in  PIX_W each  samples
y_data  out  Y_LANES*PIX_W
y_addr  out  Y_AW
y_wren  out  1
u_data, v_data  out  C_LANES*PIX_W
u_addr, v_addr  out  C_AW
u_wren, v_wren  out  1
frame_done  out  1  one-cycle pulse
err_ovf  out  1  sticky, cleared at sof
err_geom  out  1  sticky, cleared at sof

Behaviour:
- Reset: all outputs 0; col, row, lane counters, address counters 0; active mode = 4:2:0; accumulators cleared.
- Nothing advances while pix_valid=0; sof/eol ignored without pix_valid.
- sof (with pix_valid): discard any partial words (no flush), zero col/row/lanes/addresses, latch mode, clear err flags; the same pixel is processed as col 0 row 0.
- Column/row: col++ per accepted pixel; eol -> col=0, row++. Pixel with col>=IMG_W or row>=IMG_H: dropped, err_geom set.
- Sample selection: Y every pixel. Mode 0: U,V every pixel. Mode 1: U,V on even col. Mode 2: U on even col/even row, V on even col/odd row.
- Packing: first sample of a word in bits [PIX_W-1:0], next sample in the next lane up. When a plane's last lane fills, the word is written.
- eol flush: any plane with a non-empty partial word writes it on the same event, unused lanes zero.
- Write timing: data/addr/wren registered; wren is a one-cycle pulse, valid in the cycle after the completing pixel. Independent per plane; simultaneous writes on all three planes are legal.
- Addresses: per plane, start 0 at sof, +1 after each write. If a plane has already written DEPTH words, further writes on it are suppressed (wren stays 0), address holds, err_ovf set.
- frame_done: pulses in the cycle after eol on row IMG_H-1, aligned with that line's flush writes.
- Reset mid-frame: immediate clear, no partial writes emitted; packer idles until next sof. Pixels before first sof are dropped without error.

Decomposition:
- Package yuv_pack_pkg: mode constants (MODE_444, MODE_422, MODE_420), default lane counts and widths.
- Sub-module lane_packer (parametrised by LANES, PIX_W, AW, DEPTH): accumulator, lane counter, address counter, flush, overflow. Instantiated three times. Top holds col/row, mode latch, sample-select, frame_done.

Test Plan:
- Mode 0, IMG_W=10, Y_LANES=5, ramp Y=0..9 -> two Y writes, addr 0,1, data 0x0403020100 and 0x0908070605, each one cycle after pixels 4 and 9.
- Mode 1, IMG_W=6, C_LANES=18 -> at eol one U write and one V write, lanes 0-2 hold cols 0,2,4 samples, lanes 3-17 zero, addr 0.
- Mode 2, 2 lines -> U written only after row 0 eol, V only after row 1 eol, both addr 0.
- C_DEPTH=2, mode 0, 3 full chroma words -> u_wren pulses twice, third suppressed, u_addr holds 2, err_ovf=1; next sof clears it.
- sof mid-line with 3 Y samples pending -> no Y write; next full word lands at addr 0, y_data lane 0 = first new pixel.
- Row 480 pixel with IMG_H=480 -> dropped, err_geom=1, no writes; frame_done pulsed once after row 479 eol.
